output_serializer: RTL and testbench
====================================

Name: output_serializer

Overview:
- Parametrised successor to the fixed two-word nibble output loader.
- Sends a frame of NWORDS words, each W bits, as SYM_W-bit symbols, most significant symbol first, word 0 first.
- Every output symbol is tagged with the frame mode and a data flag.
- Adds ready/valid backpressure, a done pulse and synchronous abort; sits between the watchdog status/report logic and the byte-wide output port.

Parameters:
- W, 32, word width in bits; must be a multiple of SYM_W (elaboration error otherwise).
- NWORDS, 2, words per frame; minimum 1.
- SYM_W, 4, symbol (payload) width in bits.
- MODE_W, 3, mode tag width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- start  in  1  frame request; sampled only in IDLE.
- abort  in  1  synchronous frame cancel.
- mode  in  MODE_W  frame mode tag; latched on accepted start.
- words  in  NWORDS*W  frame payload; word i = words[i*W +: W]; latched on accepted start.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last symbol is accepted.
- out_valid  out  1  out_data holds a valid symbol.
- out_ready  in  1  sink accepts the symbol on a cycle where out_valid and out_ready are both high.
- out_data  out  MODE_W+1+SYM_W  {mode, flag, symbol}; 8 bits with the defaults.

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk.
- Reset values: state=IDLE, busy=0, done=0, out_valid=0, out_data=0, internal word buffer, mode register and counters all 0.
- Derived constants: SPW = W/SYM_W symbols per word; NSYM = NWORDS*SPW symbols per frame.
- All outputs are registered.

States:
- IDLE.
- SEND.
- CHK (present only with the optional feature).

IDLE:
- busy=0, out_valid=0, out_data=0.
- start=1 and abort=0 at edge k:
  - latch words and mode;
  - symbol index = NSYM-1, counted from the LSB of the flattened buffer in reverse send order, i.e. word 0, top symbol first;
  - go to SEND;
  - after edge k: out_valid=1, out_data = {mode, 1'b1, first symbol}, busy=1.
- Start-to-first-symbol latency is 1 cycle.

SEND:
- out_data and out_valid are held stable while out_valid=1 and out_ready=0. No symbol may be dropped or repeated.
- On a handshake with more symbols left, out_data loads the next symbol on the same edge. Back-to-back throughput is 1 symbol per cycle.
- Symbol order: word 0 bits [W-1 -: SYM_W] down to [SYM_W-1:0], then word 1, and so on.
- Handshake on the last symbol:
  - without CHK: go to IDLE; out_valid=0, out_data=0; done=1 for exactly one cycle.
  - with CHK: go to CHK.
- start while busy is ignored and not queued.
- Changes on words/mode while busy have no effect on the frame in flight.

abort:
- Priority over start and handshakes in any state.
- Next edge: state=IDLE, out_valid=0, out_data=0, done stays 0.
- abort and start in the same cycle in IDLE: start is ignored.

Reset mid-frame: immediate return to reset values; the frame is lost and no done pulse is produced.

NWORDS=1, SPW=1 (single-symbol frame): the first handshake completes the frame.

Optional Feature:
- Macro: OUTPUT_SERIALIZER_CHK_EN.
- Defined:
  - A running XOR of all payload symbols is accumulated as they are accepted.
  - After the last payload handshake the block enters CHK and presents out_data = {mode, 1'b0, xor}, out_valid=1. Flag 0 marks the trailer symbol.
  - The trailer obeys the same hold and abort rules as payload symbols.
  - Its handshake returns the block to IDLE with the done pulse.
  - The frame is NSYM+1 symbols.
- Undefined:
  - No CHK state and no accumulator logic.
  - Frame is NSYM symbols; flag bit is always 1 while out_valid=1.

Test Plan:
- Defaults, out_ready=1, mode=3'b101, words={32'h9ABCDEF0, 32'h12345678}, start 1 cycle:
  - out_data sequence 0xB1,0xB2,...,0xB8,0xB9,0xBA,...,0xBF,0xB0 on 16 consecutive cycles from the cycle after start;
  - then out_valid=0, out_data=0, done pulse 1 cycle, busy low.
- Same frame with out_ready toggling 1,0,0,1,...: each symbol is held while ready=0; sequence identical, no drops or repeats; done after the 16th handshake.
- abort asserted after the 5th handshake (out_data=0xB6 showing): next cycle out_valid=0, out_data=0, busy=0, no done pulse; a new start then sends the full frame from 0xB1.
- start pulsed again mid-frame with different words: ignored; the original 16 symbols complete unchanged.
- OUTPUT_SERIALIZER_CHK_EN defined, frame as above: 16 payload symbols, then trailer 0xA0 (XOR = 0); then a second frame with words={32'h0, 32'h00000001} gives trailer 0xA1.
- rst_n low mid-frame: outputs go to 0 immediately (asynchronously); after release with start, the full frame is sent correctly.

Source files
------------

// File: rtl/output_serializer.sv
// Frame serializer: NWORDS words of W bits sent as tagged SYM_W-bit symbols with ready/valid backpressure.
// Optional XOR trailer symbol enabled by defining OUTPUT_SERIALIZER_CHK_EN.
module output_serializer #(
  parameter int W      = 32,
  parameter int NWORDS = 2,
  parameter int SYM_W  = 4,
  parameter int MODE_W = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic [MODE_W-1:0]           mode,
  input  logic [NWORDS*W-1:0]         words,
  output logic                        busy,
  output logic                        done,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [MODE_W+SYM_W:0]       out_data
);

  localparam int SPW   = W / SYM_W;
  localparam int NSYM  = NWORDS * SPW;
  localparam int BUF_W = NWORDS * W;
  localparam int IDX_W = (NSYM > 1) ? $clog2(NSYM) : 1;
  localparam int OUT_W = MODE_W + 1 + SYM_W;

  generate
    if (W % SYM_W != 0) begin : g_bad_w
      $error("output_serializer: W must be a multiple of SYM_W");
    end
    if (NWORDS < 1) begin : g_bad_nwords
      $error("output_serializer: NWORDS must be at least 1");
    end
  endgenerate

`ifdef OUTPUT_SERIALIZER_CHK_EN
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_CHK} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_SEND} state_t;
`endif

  state_t             state_q, state_d;
  logic [BUF_W-1:0]   buf_q, buf_d, seq;
  logic [MODE_W-1:0]  mode_q, mode_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [OUT_W-1:0]   data_q, data_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               hs;
`ifdef OUTPUT_SERIALIZER_CHK_EN
  logic [SYM_W-1:0]   xor_q, xor_d;
`endif

  assign hs = valid_q & out_ready;

  // Rearrange the input words into send order so the next symbol is always at the top.
  always_comb begin
    seq = '0;
    for (int w = 0; w < NWORDS; w++) begin
      for (int s = 0; s < SPW; s++) begin
        seq[(NSYM - 1 - (w * SPW + SPW - 1 - s)) * SYM_W +: SYM_W] = words[w * W + s * SYM_W +: SYM_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      buf_q   <= '0;
      mode_q  <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef OUTPUT_SERIALIZER_CHK_EN
      xor_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
`ifdef OUTPUT_SERIALIZER_CHK_EN
      xor_q   <= xor_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (start) state_d = S_SEND;
        S_SEND: begin
          if (hs && idx_q == '0) begin
`ifdef OUTPUT_SERIALIZER_CHK_EN
            state_d = S_CHK;
`else
            state_d = S_IDLE;
`endif
          end
        end
`ifdef OUTPUT_SERIALIZER_CHK_EN
        S_CHK: if (hs) state_d = S_IDLE;
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    buf_d   = buf_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    data_d  = data_q;
    valid_d = valid_q;
    done_d  = 1'b0;
`ifdef OUTPUT_SERIALIZER_CHK_EN
    xor_d   = xor_q;
`endif
    if (abort) begin
      valid_d = 1'b0;
      data_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          valid_d = 1'b0;
          data_d  = '0;
          if (start) begin
            mode_d  = mode;
            buf_d   = seq << SYM_W;
            idx_d   = IDX_W'(NSYM - 1);
            data_d  = {mode, 1'b1, seq[BUF_W-1 -: SYM_W]};
            valid_d = 1'b1;
`ifdef OUTPUT_SERIALIZER_CHK_EN
            xor_d   = '0;
`endif
          end
        end
        S_SEND: begin
          if (hs) begin
`ifdef OUTPUT_SERIALIZER_CHK_EN
            xor_d = xor_q ^ data_q[SYM_W-1:0];
`endif
            if (idx_q == '0) begin
`ifdef OUTPUT_SERIALIZER_CHK_EN
              data_d  = {mode_q, 1'b0, xor_d};
              valid_d = 1'b1;
`else
              data_d  = '0;
              valid_d = 1'b0;
              done_d  = 1'b1;
`endif
            end else begin
              data_d = {mode_q, 1'b1, buf_q[BUF_W-1 -: SYM_W]};
              buf_d  = buf_q << SYM_W;
              idx_d  = idx_q - 1'b1;
            end
          end
        end
`ifdef OUTPUT_SERIALIZER_CHK_EN
        S_CHK: begin
          if (hs) begin
            data_d  = '0;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end
        end
`endif
        default: begin
          data_d  = '0;
          valid_d = 1'b0;
        end
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: tb/tb_output_serializer.sv
// Randomized bench for output_serializer against a queue-based frame model.
module tb_output_serializer;
  localparam int W      = 32;
  localparam int NWORDS = 2;
  localparam int SYM_W  = 4;
  localparam int MODE_W = 3;
  localparam int SPW    = W / SYM_W;
  localparam int OUT_W  = MODE_W + 1 + SYM_W;
`ifdef OUTPUT_SERIALIZER_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n, start, abort, out_ready;
  logic [MODE_W-1:0]    mode;
  logic [NWORDS*W-1:0]  words;
  logic                 busy, done, out_valid;
  logic [OUT_W-1:0]     out_data;
  logic [OUT_W-1:0]     expq[$];
  int                   n_tests = 0;
  int                   n_fail  = 0;

  output_serializer #(.W(W), .NWORDS(NWORDS), .SYM_W(SYM_W), .MODE_W(MODE_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode), .words(words),
    .busy(busy), .done(done), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Expected symbol stream: word 0 first, top symbol first, optional XOR trailer.
  task automatic build(input logic [NWORDS*W-1:0] f, input logic [MODE_W-1:0] m);
    logic [SYM_W-1:0] sym, x;
    expq.delete();
    x = '0;
    for (int w = 0; w < NWORDS; w++) begin
      for (int s = SPW - 1; s >= 0; s--) begin
        sym = f[w*W + s*SYM_W +: SYM_W];
        x ^= sym;
        expq.push_back({m, 1'b1, sym});
      end
    end
    if (CHK) expq.push_back({m, 1'b0, x});
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 0);
    check({tag, "_data"},  32'(out_data), 0);
    check({tag, "_busy"},  32'(busy), 0);
    check({tag, "_done"},  32'(done), 0);
  endtask

  // rmode: 0 always ready, 1 pattern 1,0,0, 2 random
  task automatic frame(input logic [NWORDS*W-1:0] f, input logic [MODE_W-1:0] m,
                       input int rmode, input int abort_at, input bit mid_start);
    int  n;
    bit  r, finished;
    build(f, m);
    start = 1'b1; mode = m; words = f;
    step();
    start = 1'b0;
    n = 0;
    finished = 1'b0;
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      start = 1'b0;
      case (rmode)
        0:       r = 1'b1;
        1:       r = (cyc % 3 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      out_ready = r;
      check("valid", 32'(out_valid), 1);
      check("data",  32'(out_data), 32'(expq[n]));
      check("busy",  32'(busy), 1);
      check("done",  32'(done), 0);
      if (n == abort_at) begin
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_idle("abort");
        step();
        check("abort_nodone", 32'(done), 0);
        return;
      end
      if (mid_start && n == 3) begin
        start = 1'b1;
        words = {$urandom, $urandom};
        mode  = ~m;
      end
      if (r) n++;
      step();
      if (n == expq.size()) begin
        check("end_done",  32'(done), 1);
        check("end_valid", 32'(out_valid), 0);
        check("end_data",  32'(out_data), 0);
        check("end_busy",  32'(busy), 0);
        step();
        check("done_pulse", 32'(done), 0);
        finished = 1'b1;
      end
    end
    start = 1'b0;
    if (!finished) check("timeout", 0, 1);
  endtask

  localparam logic [NWORDS*W-1:0] F0 = {32'h9ABCDEF0, 32'h12345678};
  localparam logic [NWORDS*W-1:0] F1 = {32'h00000000, 32'h00000001};

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    mode = '0; words = '0;
    step(); step();
    check_idle("reset");
    rst_n = 1'b1;
    step();

    frame(F0, 3'b101, 0, -1, 1'b0);
    frame(F0, 3'b101, 1, -1, 1'b0);
    frame(F0, 3'b101, 0, 5, 1'b0);
    frame(F0, 3'b101, 0, -1, 1'b0);
    frame(F0, 3'b101, 2, -1, 1'b1);
    frame(F1, 3'b101, 0, -1, 1'b0);

    // abort together with start in IDLE: start ignored
    start = 1'b1; abort = 1'b1; mode = 3'b011; words = F0;
    step();
    start = 1'b0; abort = 1'b0;
    check_idle("abort_start");

    // asynchronous reset mid-frame
    start = 1'b1; out_ready = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    #2 rst_n = 1'b0;
    #1 check_idle("async_rst");
    step();
    rst_n = 1'b1;
    step();
    frame(F0, 3'b101, 0, -1, 1'b0);

    for (int i = 0; i < 20; i++) begin
      frame({$urandom, $urandom}, MODE_W'($urandom), 2,
            (i % 5 == 4) ? int'($urandom_range(0, 15)) : -1, 1'(i % 3 == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
